// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Combinational lookup for fetch, single training port from the resolving stage.
module bpu_btb #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_uncond,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              invalidate,
    output logic              upd_mispredict,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic               uncond_q [ENTRIES];
    logic               uncond_d [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CTR_W-1:0]   ctr_d    [ENTRIES];
    logic [STAT_W-1:0]  hits_q, hits_d;
    logic [STAT_W-1:0]  mispred_q, mispred_d;

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             u_hit;
    logic             unused_pc_lsbs;

    assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

    // Lookup is masked during reset so the fetch stage never sees stale entries.
    always_comb begin
        f_idx       = fetch_pc[IDX_W+1:2];
        f_tag       = fetch_pc[ADDR_W-1:IDX_W+2];
        pred_hit    = !RST && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = pred_hit && (uncond_q[f_idx] || ctr_q[f_idx][CTR_W-1]);
        pred_target = pred_taken ? target_q[f_idx] : fetch_pc + ADDR_W'(4);
    end

    always_comb begin
        upd_mispredict = upd_valid &&
                         ((upd_pred_taken != upd_taken) ||
                          (upd_taken && (upd_pred_target != upd_target)));
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        uncond_d = uncond_q;
        ctr_d    = ctr_q;
        u_idx    = upd_pc[IDX_W+1:2];
        u_tag    = upd_pc[ADDR_W-1:IDX_W+2];
        u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

        if (invalidate) begin
            valid_d = '0;
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (ctr_q[u_idx] != CTR_MAX) ctr_d[u_idx] = ctr_q[u_idx] + CTR_W'(1);
                    target_d[u_idx] = upd_target;
                    uncond_d[u_idx] = upd_uncond;
                end else if (ctr_q[u_idx] != '0) begin
                    ctr_d[u_idx] = ctr_q[u_idx] - CTR_W'(1);
                end
            end else if (upd_taken) begin
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = upd_target;
                uncond_d[u_idx] = upd_uncond;
                ctr_d[u_idx]    = CTR_WEAK;
            end
        end
    end

    always_comb begin
        hits_d    = hits_q;
        mispred_d = mispred_q;
        if (pred_hit && (hits_q != '1)) hits_d = hits_q + STAT_W'(1);
        if (upd_mispredict && (mispred_q != '1)) mispred_d = mispred_q + STAT_W'(1);
    end

    assign stat_hits        = hits_q;
    assign stat_mispredicts = mispred_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q   <= '0;
            hits_q    <= '0;
            mispred_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            target_q  <= target_d;
            uncond_q  <= uncond_d;
            ctr_q     <= ctr_d;
            hits_q    <= hits_d;
            mispred_q <= mispred_d;
        end
    end

endmodule

// File: tb/tb_bpu_btb.sv
// Scoreboard bench for bpu_btb: a behavioural model predicts every cycle's outputs.
module tb_bpu_btb;

    localparam int unsigned AW = 32;
    localparam int unsigned NE = 16;
    localparam int unsigned CW = 2;
    localparam int unsigned SW = 4;
    localparam int SAT = 15;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] fetch_pc;
    logic          pred_hit, pred_taken;
    logic [AW-1:0] pred_target;
    logic          upd_valid, upd_uncond, upd_taken, upd_pred_taken, invalidate;
    logic [AW-1:0] upd_pc, upd_target, upd_pred_target;
    logic          upd_mispredict;
    logic [SW-1:0] stat_hits, stat_mispredicts;

    bpu_btb #(.ADDR_W(AW), .ENTRIES(NE), .CTR_W(CW), .STAT_W(SW)) dut (
        .CLK(CLK), .RST(RST), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_uncond(upd_uncond),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .invalidate(invalidate), .upd_mispredict(upd_mispredict),
        .stat_hits(stat_hits), .stat_mispredicts(stat_mispredicts)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          hit;
        logic          taken;
        logic [AW-1:0] tgt;
        logic          mis;
        int            hits;
        int            misc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    bit            m_valid [NE];
    logic [25:0]   m_tag   [NE];
    logic [AW-1:0] m_tgt   [NE];
    bit            m_unc   [NE];
    int            m_ctr   [NE];
    int            m_hits, m_mis;

    task automatic check_eq(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_lookup_hit(input logic [AW-1:0] pc);
        int i;
        i = int'(pc[5:2]);
        return m_valid[i] && (m_tag[i] == pc[31:6]);
    endfunction

    task automatic m_predict(input logic [AW-1:0] pc, output logic tk, output logic [AW-1:0] tgt);
        int i;
        i   = int'(pc[5:2]);
        tk  = m_lookup_hit(pc) && (m_unc[i] || (m_ctr[i] >= 2));
        tgt = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic cyc(input logic [AW-1:0] fpc, input logic uv, input logic [AW-1:0] upc,
                       input logic unc, input logic tk, input logic [AW-1:0] utgt,
                       input logic ptk, input logic [AW-1:0] ptgt,
                       input logic inv, input logic rst);
        exp_t e, o;
        logic ltk;
        logic [AW-1:0] ltgt;
        int ui;
        @(negedge CLK);
        fetch_pc = fpc; upd_valid = uv; upd_pc = upc; upd_uncond = unc; upd_taken = tk;
        upd_target = utgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
        invalidate = inv; RST = rst;
        m_predict(fpc, ltk, ltgt);
        e.hit   = !rst && m_lookup_hit(fpc);
        e.taken = !rst && ltk;
        e.tgt   = rst ? fpc + 32'd4 : ltgt;
        e.mis   = uv && ((ptk != tk) || (tk && (ptgt != utgt)));
        e.hits  = m_hits;
        e.misc  = m_mis;
        sb.push_back(e);
        #1;
        o = sb.pop_front();
        check_eq("pred_hit", {31'd0, pred_hit}, {31'd0, o.hit});
        check_eq("pred_taken", {31'd0, pred_taken}, {31'd0, o.taken});
        check_eq("pred_target", pred_target, o.tgt);
        check_eq("upd_mispredict", {31'd0, upd_mispredict}, {31'd0, o.mis});
        check_eq("stat_hits", {28'd0, stat_hits}, o.hits);
        check_eq("stat_mispredicts", {28'd0, stat_mispredicts}, o.misc);
        // model state for the coming edge
        if (rst) begin
            for (int i = 0; i < NE; i++) begin m_valid[i] = 0; m_ctr[i] = 0; end
            m_hits = 0; m_mis = 0;
        end else begin
            if (o.hit && m_hits < SAT) m_hits++;
            if (o.mis && m_mis < SAT) m_mis++;
            if (inv) begin
                for (int i = 0; i < NE; i++) m_valid[i] = 0;
            end else if (uv) begin
                ui = int'(upc[5:2]);
                if (m_lookup_hit(upc)) begin
                    if (tk) begin
                        if (m_ctr[ui] < 3) m_ctr[ui]++;
                        m_tgt[ui] = utgt; m_unc[ui] = unc;
                    end else if (m_ctr[ui] > 0) m_ctr[ui]--;
                end else if (tk) begin
                    m_valid[ui] = 1; m_tag[ui] = upc[31:6]; m_tgt[ui] = utgt;
                    m_unc[ui] = unc; m_ctr[ui] = 2;
                end
            end
        end
    endtask

    task automatic fetch(input logic [AW-1:0] fpc);
        cyc(fpc, 0, 32'd0, 0, 0, 32'd0, 0, 32'd0, 0, 0);
    endtask

    task automatic train(input logic [AW-1:0] fpc, input logic [AW-1:0] upc,
                         input logic unc, input logic tk, input logic [AW-1:0] tgt);
        logic ptk;
        logic [AW-1:0] ptgt;
        m_predict(upc, ptk, ptgt);
        cyc(fpc, 1, upc, unc, tk, tgt, ptk, ptgt, 0, 0);
    endtask

    logic [AW-1:0] pool [6];

    initial begin
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_unc[i] = 0; m_ctr[i] = 0;
        end
        m_hits = 0; m_mis = 0;
        RST = 1'b1; fetch_pc = '0; upd_valid = 0; upd_pc = '0; upd_uncond = 0;
        upd_taken = 0; upd_target = '0; upd_pred_taken = 0; upd_pred_target = '0; invalidate = 0;
        repeat (2) @(posedge CLK);

        cyc(32'h0040_0010, 0, 32'd0, 0, 0, 32'd0, 0, 32'd0, 0, 1);
        fetch(32'h0040_0010);
        fetch(32'hFFFF_FFFC);

        // first allocation; same-cycle lookup still sees the old contents
        train(32'h0040_0010, 32'h0040_0010, 0, 1, 32'h0040_0100);
        fetch(32'h0040_0010);
        fetch(32'h0040_0010);

        repeat (2) train(32'h0040_0010, 32'h0040_0010, 0, 0, 32'h0);
        fetch(32'h0040_0010);
        repeat (3) train(32'h0040_0010, 32'h0040_0010, 0, 0, 32'h0);
        train(32'h0040_0010, 32'h0040_0010, 0, 1, 32'h0040_0100);
        fetch(32'h0040_0010);

        train(32'h0040_0050, 32'h0040_0050, 0, 1, 32'h0040_0200);
        fetch(32'h0040_0010);
        fetch(32'h0040_0050);
        train(32'h0040_0090, 32'h0040_0090, 0, 0, 32'h0);
        fetch(32'h0040_0050);
        fetch(32'h0040_0090);

        train(32'h0000_0020, 32'h0000_0020, 1, 1, 32'h0000_0800);
        fetch(32'h0000_0020);
        repeat (2) train(32'h0000_0020, 32'h0000_0020, 1, 0, 32'h0);
        fetch(32'h0000_0020);

        cyc(32'h0000_0020, 1, 32'h0000_0100, 0, 1, 32'h0000_0400, 0, 32'h0000_0104, 1, 0);
        fetch(32'h0000_0020);
        fetch(32'h0040_0050);
        fetch(32'h0000_0100);

        train(32'h0040_0010, 32'h0040_0010, 0, 1, 32'h0040_0100);
        repeat (20) fetch(32'h0040_0010);
        repeat (18) cyc(32'h0040_0010, 1, 32'h0040_0010, 0, 1, 32'h0040_0100, 0, 32'h0040_0014, 0, 0);
        fetch(32'h0040_0010);
        // reset wins over a same-cycle allocating update and over invalidate
        cyc(32'h0040_0010, 1, 32'h0000_0100, 0, 1, 32'h0000_0400, 0, 32'h0000_0104, 1, 1);
        fetch(32'h0040_0010);
        fetch(32'h0000_0100);

        pool[0] = 32'h0040_0010; pool[1] = 32'h0040_0050; pool[2] = 32'h0040_0090;
        pool[3] = 32'h0000_0020; pool[4] = 32'h0000_0100; pool[5] = 32'h1234_567C;
        for (int n = 0; n < 300; n++) begin
            logic ptk;
            logic [AW-1:0] ptgt, upc, fpc, utgt;
            fpc  = pool[$urandom_range(5)];
            upc  = pool[$urandom_range(5)];
            utgt = {$urandom_range(32'h3FFF_FFFF), 2'b00};
            m_predict(upc, ptk, ptgt);
            if ($urandom_range(7) == 0) ptk = ~ptk;
            if ($urandom_range(7) == 0) ptgt = utgt;
            cyc(fpc, 1'($urandom_range(1)), upc, 1'($urandom_range(3) == 0),
                1'($urandom_range(1)), utgt, ptk, ptgt,
                ($urandom_range(40) == 0), ($urandom_range(100) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
